// File: rtl/core_seq.sv
// core_seq -- multi-cycle instruction sequencer.
//
// Steps each instruction through IDLE -> FETCH -> DECODE -> (MEM) -> WB and
// raises the datapath strobes for each step. The instruction class is
// captured in DECODE and held for the rest of the instruction.
//
// Optional feature macro: CORE_SEQ_TIMEOUT_EN
//   defined   : bus-ack watchdog; a request left without an ack for
//               TIMEOUT_CYCLES cycles sends the FSM to HALT and sets err.
//   undefined : no watchdog; err is tied to 0; requests wait forever.
//
// Parameters:
//   RESET_HOLD     cycles spent in IDLE after reset release (1..15)
//   TIMEOUT_CYCLES bus-ack watchdog limit (1..255), watchdog build only
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   inst_type  decoder class, sampled in DECODE only
//   imem_req   instruction fetch request      imem_ack  fetch data valid
//   dmem_req   data access request            dmem_we   data access is a store
//   dmem_ack   data access complete
//   inst_we    latch fetched word             reg_we    register-file write
//   csr_we     CSR write                      pc_we     PC update
//   pc_jump    PC source: 1 jump target, 0 pc+4 (valid with pc_we)
//   state      current FSM state              retired   retired-instruction count
//   halted     FSM is in HALT                 err       bus timeout occurred
module core_seq #(
    parameter int unsigned RESET_HOLD     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  inst_type,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        inst_we,
    output logic        reg_we,
    output logic        csr_we,
    output logic        pc_we,
    output logic        pc_jump,
    output logic [2:0]  state,
    output logic [31:0] retired,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [3:0]  hold_cnt_r;
    logic [4:0]  inst_r;
    logic [31:0] retired_r;
    logic        timeout_s;
    logic        err_set_s;
    logic        wait_s;

    function automatic logic is_store(input logic [4:0] cls);
        return (cls[4:2] == 3'b011);
    endfunction

    function automatic logic is_csr(input logic [4:0] cls);
        return (cls[4:3] == 2'b10);
    endfunction

    // Next-state and strobe decode from the current state and the acks.
    always_comb begin
        state_nx_s = state_r;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        inst_we    = 1'b0;
        reg_we     = 1'b0;
        csr_we     = 1'b0;
        pc_we      = 1'b0;
        pc_jump    = 1'b0;
        err_set_s  = 1'b0;
        wait_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (hold_cnt_r == 4'(RESET_HOLD - 1)) begin
                    state_nx_s = FETCH;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    inst_we    = 1'b1;
                    state_nx_s = DECODE;
                end else if (timeout_s) begin
                    err_set_s  = 1'b1;
                    state_nx_s = HALT;
                end else begin
                    wait_s     = 1'b1;
                    state_nx_s = FETCH;
                end
            end
            DECODE: begin
                casez (inst_type)
                    5'b010??, 5'b011??:                         state_nx_s = MEM;
                    5'b00001, 5'b00010, 5'b00011, 5'b00100,
                    5'b10???:                                   state_nx_s = WB;
                    default:                                    state_nx_s = HALT;
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store(inst_r);
                if (dmem_ack) begin
                    if (is_store(inst_r)) begin
                        pc_we      = 1'b1;
                        state_nx_s = FETCH;
                    end else begin
                        state_nx_s = WB;
                    end
                end else if (timeout_s) begin
                    err_set_s  = 1'b1;
                    state_nx_s = HALT;
                end else begin
                    wait_s     = 1'b1;
                    state_nx_s = MEM;
                end
            end
            WB: begin
                pc_we      = 1'b1;
                reg_we     = !is_store(inst_r);
                csr_we     = is_csr(inst_r);
                pc_jump    = (inst_r == 5'b00100);
                state_nx_s = FETCH;
            end
            HALT: begin
                state_nx_s = HALT;
            end
            default: begin
                // Unused encodings 6 and 7 fall into HALT.
                state_nx_s = HALT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // IDLE dwell counter; restarts whenever the FSM is outside IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt_r <= 4'd0;
        end else if (state_r == IDLE) begin
            hold_cnt_r <= hold_cnt_r + 4'd1;
        end else begin
            hold_cnt_r <= 4'd0;
        end
    end

    // Instruction class captured in DECODE so later inst_type changes are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            inst_r <= 5'd0;
        end else if (state_r == DECODE) begin
            inst_r <= inst_type;
        end else begin
            inst_r <= inst_r;
        end
    end

    // Retired-instruction counter, one per PC update, wraps naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            retired_r <= 32'd0;
        end else if (pc_we) begin
            retired_r <= retired_r + 32'd1;
        end else begin
            retired_r <= retired_r;
        end
    end

`ifdef CORE_SEQ_TIMEOUT_EN
    logic [7:0] wait_cnt_r;
    logic       err_r;

    // Limit is hit in the cycle whose no-ack wait would bring the count to TIMEOUT_CYCLES.
    assign timeout_s = ((wait_cnt_r + 8'd1) == 8'(TIMEOUT_CYCLES));

    // Wait counter: counts unacked request cycles, cleared by any ack or non-request state.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_r <= 8'd0;
        end else if (wait_s) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= 8'd0;
        end
    end

    // Sticky timeout flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    logic unused_timeout_s;

    assign timeout_s        = 1'b0;
    assign err              = 1'b0;
    assign unused_timeout_s = ^{8'(TIMEOUT_CYCLES), wait_s, err_set_s};
`endif

    assign state   = state_r;
    assign retired = retired_r;
    assign halted  = (state_r == HALT);

endmodule

// File: tb/tb_core_seq.sv
// Testbench for core_seq: a per-cycle expectation queue built from the
// instruction-level timing rules, driven and compared by one process, plus
// literal checks on timing/count summaries gathered while running.
module tb_core_seq;

    localparam int RH = 2;
    localparam int TO = 8;
    localparam logic [4:0] J = 5'b00000;   // value driven on inst_type outside DECODE
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  inst_type = 5'd0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, dmem_we, inst_we, reg_we, csr_we, pc_we, pc_jump;
    logic [2:0]  state;
    logic [31:0] retired;
    logic        halted, err;

    core_seq #(.RESET_HOLD(RH), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .inst_type(inst_type),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .inst_we(inst_we), .reg_we(reg_we), .csr_we(csr_we),
        .pc_we(pc_we), .pc_jump(pc_jump), .state(state),
        .retired(retired), .halted(halted), .err(err)
    );

    always #5 clock = ~clock;

    // strb = {imem_req, dmem_req, dmem_we, inst_we, reg_we, csr_we, pc_we, pc_jump}
    typedef struct {
        logic        rst;
        logic        ia;
        logic        da;
        logic [4:0]  it;
        logic        chk;
        logic [2:0]  st;
        logic [7:0]  strb;
        logic        er;
        logic [31:0] ret;
    } item_t;

    item_t       q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_ret = 32'd0;
    logic        m_err = 1'b0;

    // observation summaries, cleared on each reset cycle
    int cyc = 0, first_pw = 0, last_pw = 0, bad_gap = 0, pw_cnt = 0;
    int dreq_cnt = 0, dwe_cnt = 0, rwe_cnt = 0, rwe_cyc = 0, cwe_cnt = 0;
    int pj_cnt = 0, dack_cyc = 0, hlt_cnt = 0, ireq_in_halt = 0;

    task automatic put(input logic rst, input logic ia, input logic da, input logic [4:0] it,
                       input logic chk, input logic [2:0] st, input logic [7:0] strb);
        item_t x;
        x.rst = rst; x.ia = ia; x.da = da; x.it = it; x.chk = chk;
        x.st = st; x.strb = strb; x.er = m_err; x.ret = m_ret;
        q.push_back(x);
        if (strb[1]) m_ret = m_ret + 32'd1;
    endtask

    task automatic do_reset();
        put(1'b1, 1'b0, 1'b0, J, 1'b0, S_IDLE, 8'h00);
        m_ret = 32'd0;
        m_err = 1'b0;
        for (int i = 0; i < RH; i++) put(1'b0, 1'b1, 1'b1, J, 1'b1, S_IDLE, 8'h00);
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) put(1'b0, 1'b1, 1'b1, J, 1'b1, S_HALT, 8'h00);
    endtask

    task automatic fetch(input int fw, input logic [4:0] it);
        for (int i = 0; i < fw; i++) put(1'b0, 1'b0, 1'b1, J, 1'b1, S_FETCH, 8'b1000_0000);
        put(1'b0, 1'b1, 1'b1, J, 1'b1, S_FETCH, 8'b1001_0000);
        put(1'b0, 1'b1, 1'b1, it, 1'b1, S_DECODE, 8'h00);
    endtask

    task automatic wb(input logic [4:0] it);
        put(1'b0, 1'b1, 1'b1, J, 1'b1, S_WB,
            {4'b0000, 1'b1, (it[4:3] == 2'b10), 1'b1, (it == 5'b00100)});
    endtask

    task automatic instr(input logic [4:0] it, input int fw, input int mw);
        logic we;
        fetch(fw, it);
        we = (it[4:2] == 3'b011);
        casez (it)
            5'b010??, 5'b011??: begin
                for (int i = 0; i < mw; i++)
                    put(1'b0, 1'b1, 1'b0, J, 1'b1, S_MEM, {1'b0, 1'b1, we, 5'b00000});
                put(1'b0, 1'b1, 1'b1, J, 1'b1, S_MEM, {1'b0, 1'b1, we, 3'b000, we, 1'b0});
                if (!we) wb(it);
            end
            5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b10???: wb(it);
            default: halt_cycles(6);
        endcase
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d items left, expected 0", q.size());
            q.delete();
        end
        @(posedge clock);
        #2;
    endtask

    // Drive each queued cycle after the rising edge, compare at the falling edge.
    initial begin : drive_check
        item_t       cur;
        logic [9:0]  act_v, exp_v;
        logic        live;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() == 0) begin
                live = 1'b0;
                reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; inst_type = J;
            end else begin
                live = 1'b1;
                cur = q.pop_front();
                reset = cur.rst; imem_ack = cur.ia; dmem_ack = cur.da; inst_type = cur.it;
            end
            @(negedge clock);
            if (live && cur.chk) begin
                act_v = {imem_req, dmem_req, dmem_we, inst_we, reg_we, csr_we,
                         pc_we, pc_jump & pc_we, halted, err};
                exp_v = {cur.strb, (cur.st == S_HALT), cur.er};
                checks++;
                if (act_v !== exp_v || state !== cur.st) begin
                    errors++;
                    $display("FAIL cycle%0d outputs: got state=%0d strb=%b, expected state=%0d strb=%b",
                             cyc, state, act_v, cur.st, exp_v);
                end
                checks++;
                if (retired !== cur.ret) begin
                    errors++;
                    $display("FAIL cycle%0d retired: got %0d, expected %0d", cyc, retired, cur.ret);
                end
            end
            if (live) begin
                if (cur.rst) begin
                    cyc = 0; first_pw = 0; last_pw = 0; bad_gap = 0; pw_cnt = 0;
                    dreq_cnt = 0; dwe_cnt = 0; rwe_cnt = 0; rwe_cyc = 0; cwe_cnt = 0;
                    pj_cnt = 0; dack_cyc = 0; hlt_cnt = 0; ireq_in_halt = 0;
                end else begin
                    cyc++;
                    if (pc_we) begin
                        if (first_pw == 0) first_pw = cyc;
                        else if (cyc - last_pw != 3) bad_gap++;
                        last_pw = cyc;
                        pw_cnt++;
                        if (pc_jump) pj_cnt++;
                    end
                    if (dmem_req) dreq_cnt++;
                    if (dmem_req && dmem_we) dwe_cnt++;
                    if (dmem_req && dmem_ack) dack_cyc = cyc;
                    if (reg_we) begin rwe_cnt++; rwe_cyc = cyc; end
                    if (csr_we) cwe_cnt++;
                    if (halted) hlt_cnt++;
                    if (halted && imem_req) ireq_in_halt++;
                end
            end
        end
    end

    initial begin : stim
        // reset state, directly after the first edge with reset high
        @(posedge clock);
        #3;
        lit("reset_state", {29'd0, state}, 32'd0);
        lit("reset_retired", retired, 32'd0);
        lit("reset_flags", {28'd0, imem_req, dmem_req, halted, err}, 32'd0);

        // back-to-back imm-ALU instructions
        do_reset();
        for (int i = 0; i < 5; i++) instr(5'b00001, 0, 0);
        drain();
        lit("alu_first_pc_we_cycle", first_pw, 32'd5);
        lit("alu_pc_we_gap", bad_gap, 32'd0);
        lit("alu_retired", retired, 32'd5);

        // load with dmem_ack delayed 4 cycles
        do_reset();
        instr(5'b01010, 0, 4);
        drain();
        lit("load_dmem_req_cycles", dreq_cnt, 32'd5);
        lit("load_dmem_we", dwe_cnt, 32'd0);
        lit("load_reg_we_after_ack", rwe_cyc - dack_cyc, 32'd1);
        lit("load_retired", retired, 32'd1);

        // store with immediate ack
        do_reset();
        instr(5'b01110, 0, 0);
        drain();
        lit("store_dmem_we", dwe_cnt, 32'd1);
        lit("store_reg_we", rwe_cnt, 32'd0);
        lit("store_pc_we_cycle", first_pw, 32'd5);
        lit("store_ack_cycle", dack_cyc, 32'd5);

        // jump then CSR, plus the remaining ALU classes
        do_reset();
        instr(5'b00100, 1, 0);
        instr(5'b10001, 0, 0);
        instr(5'b00010, 0, 0);
        instr(5'b00011, 0, 0);
        drain();
        lit("jump_csr_pc_jump", pj_cnt, 32'd1);
        lit("jump_csr_csr_we", cwe_cnt, 32'd1);
        lit("jump_csr_reg_we", rwe_cnt, 32'd4);
        lit("jump_csr_retired", retired, 32'd4);

        // illegal class halts; HALT is absorbing with acks present
        do_reset();
        instr(5'b00000, 0, 0);
        drain();
        lit("halt_cycles", hlt_cnt, 32'd6);
        lit("halt_imem_req", ireq_in_halt, 32'd0);
        do_reset();
        instr(5'b00010, 0, 0);
        instr(5'b11000, 0, 0);
        drain();
        lit("undefined_class_halt", hlt_cnt, 32'd6);

        // reset while waiting in MEM, then normal operation
        do_reset();
        fetch(0, 5'b01000);
        put(1'b0, 1'b1, 1'b0, J, 1'b1, S_MEM, 8'b0100_0000);
        put(1'b1, 1'b1, 1'b0, J, 1'b1, S_MEM, 8'b0100_0000);
        m_ret = 32'd0;
        for (int i = 0; i < RH; i++) put(1'b0, 1'b1, 1'b1, J, 1'b1, S_IDLE, 8'h00);
        instr(5'b00011, 0, 0);
        drain();
        lit("reset_in_mem_retired", retired, 32'd1);

`ifdef CORE_SEQ_TIMEOUT_EN
        // ack on the 8th request cycle wins; counter restarts for the next fetch
        do_reset();
        instr(5'b00001, TO - 1, 0);
        instr(5'b01000, TO - 1, TO - 1);
        drain();
        lit("ack_at_limit_err", {31'd0, err}, 32'd0);
        lit("ack_at_limit_retired", retired, 32'd2);
        // no ack: 8 request cycles, then HALT with err
        do_reset();
        for (int i = 0; i < TO; i++) put(1'b0, 1'b0, 1'b1, J, 1'b1, S_FETCH, 8'b1000_0000);
        m_err = 1'b1;
        halt_cycles(4);
        drain();
        lit("timeout_err", {31'd0, err}, 32'd1);
        lit("timeout_halted", {31'd0, halted}, 32'd1);
`else
        // without the watchdog a fetch waits indefinitely
        do_reset();
        instr(5'b00001, 40, 0);
        drain();
        lit("no_timeout_err", {31'd0, err}, 32'd0);
        lit("no_timeout_retired", retired, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_seq.md
CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 SHALL have parameter RESET_HOLD, default 1, giving the number of cycles spent in IDLE after reset release (range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the bus-ack watchdog limit (range 1..255); it is used only with CORE_SEQ_TIMEOUT_EN.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port inst_type, input, 5 bits: decoder class, sampled only in DECODE. Encodings: 00000 illegal; 00001 imm-ALU; 00010 reg-ALU; 00011 upper-imm; 00100 jump; 010xx load; 011xx store; 10xxx CSR/system.
REQ-006 SHALL have port imem_req, output, 1 bit: instruction fetch request.
REQ-007 SHALL have port imem_ack, input, 1 bit: fetch data valid this cycle.
REQ-008 SHALL have port dmem_req, output, 1 bit: data access request.
REQ-009 SHALL have port dmem_we, output, 1 bit: data access is a store.
REQ-010 SHALL have port dmem_ack, input, 1 bit: data access complete; load data valid.
REQ-011 SHALL have port inst_we, output, 1 bit: latch the fetched word into the instruction register.
REQ-012 SHALL have port reg_we, output, 1 bit: register-file write strobe.
REQ-013 SHALL have port csr_we, output, 1 bit: CSR write strobe.
REQ-014 SHALL have port pc_we, output, 1 bit: PC update strobe.
REQ-015 SHALL have port pc_jump, output, 1 bit: PC source select, 1 = jump target, 0 = pc+4; meaningful only when pc_we=1.
REQ-016 SHALL have port state, output, 3 bits: current state.
REQ-017 SHALL have port retired, output, 32 bits: retired-instruction count.
REQ-018 SHALL have port halted, output, 1 bit: sequencer is in HALT.
REQ-019 SHALL have port err, output, 1 bit: bus timeout occurred.

Function
REQ-020 SHALL implement the states IDLE=0, FETCH=1, DECODE=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to HALT on the next cycle.
REQ-021 In IDLE, all strobes SHALL be 0, and the FSM SHALL move to FETCH after RESET_HOLD cycles.
REQ-022 In FETCH, imem_req SHALL be held at 1 until imem_ack; in the ack cycle inst_we=1 and the next state is DECODE. imem_req SHALL be 0 in DECODE.
REQ-023 DECODE SHALL last exactly 1 cycle, with next state chosen by inst_type:
  - 010xx or 011xx: MEM
  - 00000: HALT
  - 00001..00100 and 10xxx: WB
  - any other code: HALT
REQ-024 In MEM, dmem_req SHALL be held at 1 and dmem_we = (inst_type[4:2]==011) until dmem_ack.
  - Store ack: pc_we=1, retired increments, next state FETCH.
  - Load ack: next state WB.
REQ-025 WB SHALL last exactly 1 cycle with pc_we=1 and the next state FETCH.
  - reg_we=1 for all non-store classes.
  - csr_we=1 only for 10xxx.
  - pc_jump=1 only for 00100.
REQ-026 The FSM SHALL sample inst_type only in DECODE, hold it in an internal register, and ignore inst_type changes after DECODE.
REQ-027 retired SHALL increment by 1 on every cycle with pc_we=1 and wrap from FFFF_FFFF to 0.
REQ-028 An imem_ack or dmem_ack arriving while the corresponding req=0 SHALL be ignored.
REQ-029 Minimum instruction latency SHALL be: ALU 3 cycles (FETCH, DECODE, WB); load 4; store 3, each with single-cycle acks.
REQ-030 HALT SHALL be absorbing: all strobes and reqs 0, halted=1, exited only by reset.

Reset
REQ-031 When reset=1 at a clock edge, the FSM SHALL go to IDLE, with retired=0, err=0, and all strobes, reqs, and halted=0 from the next cycle onward; reset mid-transaction SHALL drop the req without waiting for ack.

Configuration
REQ-032 With CORE_SEQ_TIMEOUT_EN defined, an 8-bit wait counter SHALL clear on entry to FETCH or MEM and count each cycle with req=1 and no ack.
  - When the count reaches TIMEOUT_CYCLES: go to HALT and set err=1 (sticky until reset).
  - An ack in the same cycle as the limit SHALL win.
REQ-033 Without CORE_SEQ_TIMEOUT_EN, there SHALL be no counter, err SHALL be tied to 0, and requests SHALL wait indefinitely.

Verification
REQ-034 The bench SHALL check: reset, then imem_ack=1 always, inst_type=00001 -> first pc_we at cycle RESET_HOLD+3 after reset release, then every 3 cycles; retired=5 after 5 instructions.
REQ-035 The bench SHALL check: load 01010 with dmem_ack delayed 4 cycles -> dmem_req high 5 cycles, dmem_we=0, reg_we one cycle after ack, retired +1.
REQ-036 The bench SHALL check: store 01110 with immediate ack -> dmem_we=1, reg_we never 1, pc_we in the ack cycle.
REQ-037 The bench SHALL check: jump 00100 -> WB with reg_we=1, pc_jump=1; CSR 10001 -> csr_we=1, reg_we=1, pc_jump=0.
REQ-038 The bench SHALL check: inst_type=00000 -> HALT, halted=1, no further imem_req until reset; reset asserted during MEM wait -> dmem_req=0 next cycle, state=IDLE.
REQ-039 The bench SHALL check: with CORE_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, imem_ack held 0 -> HALT and err=1 after 8 request cycles; imem_ack on the 8th cycle -> DECODE, err=0.
